// File: rtl/micro_pkg.sv
// Shared constants, condition encodings and state type for the micro-sequencer.
// The optional step counter is enabled with MICRO_SEQ_STEP_CNT_EN.
package micro_pkg;

  localparam int ADDR_W      = 16;
  localparam int JUMP_W      = 7;
  localparam int FETCH_ADDR  = 1;
  localparam int IDLE_ADDR   = 0;
  localparam int UCODE_DEPTH = 86;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10,
    ERR    = 2'b11
  } seq_state_e;

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next-address decoder: branch/dispatch selection, self-loop
// halt detection and illegal-target detection for the micro-sequencer.
module micro_next_addr
  import micro_pkg::*;
#(
  parameter int P_ADDR_W      = ADDR_W,
  parameter int P_JUMP_W      = JUMP_W,
  parameter int P_UCODE_DEPTH = UCODE_DEPTH
) (
  input  logic [P_ADDR_W-1:0] upc,
  input  logic                bt,
  input  logic [1:0]          condition,
  input  logic [P_JUMP_W-1:0] jump_addr,
  input  logic [P_JUMP_W-1:0] ir_opcode,
  input  logic                z_flag,
  output logic [P_ADDR_W-1:0] next_addr,
  output logic                halt,
  output logic                illegal
);

  logic [P_ADDR_W:0]   inc_s;
  logic [P_ADDR_W-1:0] jump_ext_s;
  logic [P_ADDR_W-1:0] disp_ext_s;
  logic                use_inc_s;

  // Select the next micro-address and flag halt / illegal targets
  always_comb begin
    inc_s      = {1'b0, upc} + {{P_ADDR_W{1'b0}}, 1'b1};
    jump_ext_s = {{(P_ADDR_W-P_JUMP_W){1'b0}}, jump_addr};
    disp_ext_s = {{(P_ADDR_W-P_JUMP_W){1'b0}}, ir_opcode};
    use_inc_s  = 1'b0;
    next_addr  = inc_s[P_ADDR_W-1:0];

    if (bt) begin
      next_addr = disp_ext_s;
    end else begin
      case (condition)
        COND_ALWAYS: next_addr = jump_ext_s;
        COND_Z: begin
          if (z_flag) begin
            next_addr = jump_ext_s;
          end else begin
            use_inc_s = 1'b1;
          end
        end
        COND_NZ: begin
          if (z_flag) begin
            use_inc_s = 1'b1;
          end else begin
            next_addr = jump_ext_s;
          end
        end
        COND_RSVD: use_inc_s = 1'b1;
        default:   use_inc_s = 1'b1;
      endcase
    end

    // Self-loop at the idle word is a legitimate wait, not a halt
    halt    = !bt && (condition == COND_ALWAYS) && (jump_ext_s == upc)
              && (upc != P_ADDR_W'(IDLE_ADDR));
    illegal = (use_inc_s && inc_s[P_ADDR_W])
              || (next_addr >= P_ADDR_W'(P_UCODE_DEPTH));
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program counter and state machine for the microcoded control unit.
// Define MICRO_SEQ_STEP_CNT_EN to add the saturating step_cnt output.
module micro_sequencer
  import micro_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              z_flag,
  input  logic [JUMP_W-1:0] ir_opcode,
  input  logic              bt,
  input  logic [1:0]        condition,
  input  logic [JUMP_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] upc,
`ifdef MICRO_SEQ_STEP_CNT_EN
  output logic [31:0]       step_cnt,
`endif
  output logic              busy,
  output logic              halted,
  output logic              ucode_err
);

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   upc_q, upc_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   next_addr_s;
  logic                halt_s;
  logic                illegal_s;

  micro_next_addr #(
    .P_ADDR_W      (ADDR_W),
    .P_JUMP_W      (JUMP_W),
    .P_UCODE_DEPTH (UCODE_DEPTH)
  ) u_next_addr (
    .upc       (upc_q),
    .bt        (bt),
    .condition (condition),
    .jump_addr (jump_addr),
    .ir_opcode (ir_opcode),
    .z_flag    (z_flag),
    .next_addr (next_addr_s),
    .halt      (halt_s),
    .illegal   (illegal_s)
  );

  // Next state, next upc and registered status flags
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          upc_d   = ADDR_W'(FETCH_ADDR);
        end else begin
          upc_d   = ADDR_W'(IDLE_ADDR);
        end
      end
      RUN: begin
        // Stall outranks every branch outcome, including halt and error
        if (stall) begin
          upc_d = upc_q;
        end else if (illegal_s) begin
          state_d = ERR;
          upc_d   = ADDR_W'(IDLE_ADDR);
          err_d   = 1'b1;
        end else if (halt_s) begin
          state_d = HALTED;
          upc_d   = upc_q;
        end else begin
          upc_d   = next_addr_s;
        end
      end
      HALTED: begin
        if (start) begin
          state_d = RUN;
          upc_d   = ADDR_W'(FETCH_ADDR);
        end else begin
          upc_d   = upc_q;
        end
      end
      ERR: begin
        if (start) begin
          state_d = RUN;
          upc_d   = ADDR_W'(FETCH_ADDR);
        end else begin
          upc_d   = ADDR_W'(IDLE_ADDR);
        end
      end
      default: begin
        state_d = IDLE;
        upc_d   = ADDR_W'(IDLE_ADDR);
      end
    endcase

    busy_d   = (state_d == RUN);
    halted_d = (state_d == HALTED);
  end

  // State, upc and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      upc_q    <= ADDR_W'(IDLE_ADDR);
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      upc_q    <= upc_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

`ifdef MICRO_SEQ_STEP_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating count of executed (non-stalled) RUN cycles
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN) begin
      if (!stall && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_d = cnt_q + 32'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (start) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Step counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_cnt = cnt_q;
`endif

  assign upc       = upc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign ucode_err = err_q;

endmodule
